// File: rtl/conv33_pkg.sv
// Shared constants for the conv33 datapath: pixel width, image geometry
// and kernel size, common to the window generator and the calculator.
package conv33_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned IMG_W      = 28;
    localparam int unsigned IMG_H      = 28;
    localparam int unsigned WIN_K      = 3;

endpackage

// File: rtl/conv33_line_buf.sv
// One image row of pixel storage; asynchronous read, synchronous write at the
// same address, so a cycle's read returns the value from before that write.
module conv33_line_buf
    import conv33_pkg::*;
#(
    parameter int unsigned DEPTH     = IMG_W,
    parameter int unsigned WIDTH     = DATA_WIDTH,
    parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]     wr_data,
    output logic [WIDTH-1:0]     rd_data_c
);

    // No reset: contents are don't-care until overwritten by the stream.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[addr];

endmodule

// File: rtl/conv33_window_gen.sv
// Streaming 3x3 sliding-window generator: buffers two rows and emits each
// fully-interior 3x3 neighbourhood with a one-cycle win_valid pulse.
module conv33_window_gen
    import conv33_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = conv33_pkg::DATA_WIDTH,
    parameter int unsigned IMG_W      = conv33_pkg::IMG_W,
    parameter int unsigned IMG_H      = conv33_pkg::IMG_H,
    parameter int unsigned COL_BITS   = $clog2(IMG_W),
    parameter int unsigned ROW_BITS   = $clog2(IMG_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] data_0_0,
    output logic [DATA_WIDTH-1:0] data_0_1,
    output logic [DATA_WIDTH-1:0] data_0_2,
    output logic [DATA_WIDTH-1:0] data_1_0,
    output logic [DATA_WIDTH-1:0] data_1_1,
    output logic [DATA_WIDTH-1:0] data_1_2,
    output logic [DATA_WIDTH-1:0] data_2_0,
    output logic [DATA_WIDTH-1:0] data_2_1,
    output logic [DATA_WIDTH-1:0] data_2_2,
    output logic                  win_valid,
    output logic [ROW_BITS-1:0]   win_row,
    output logic [COL_BITS-1:0]   win_col,
    output logic                  frame_done
);

    logic [COL_BITS-1:0]   col_q;
    logic [ROW_BITS-1:0]   row_q;
    logic [COL_BITS-1:0]   col_eff;
    logic [ROW_BITS-1:0]   row_eff;
    logic                  col_last;
    logic                  row_last;
    logic                  win_hit;
    logic [DATA_WIDTH-1:0] line0_rd;
    logic [DATA_WIDTH-1:0] line1_rd;
    logic [DATA_WIDTH-1:0] col_new [WIN_K];

    // Window history keeps the two older columns; the newest column comes
    // straight from the line buffers and the incoming pixel.
    logic [DATA_WIDTH-1:0] win_sr  [WIN_K][WIN_K-1];
    logic [DATA_WIDTH-1:0] win_q   [WIN_K][WIN_K];

    // frame_start makes the current pixel (0,0) regardless of the counters.
    always_comb begin
        col_eff  = frame_start ? '0 : col_q;
        row_eff  = frame_start ? '0 : row_q;
        col_last = (col_eff == COL_BITS'(IMG_W - 1));
        row_last = (row_eff == ROW_BITS'(IMG_H - 1));
        win_hit  = in_valid && (row_eff >= ROW_BITS'(2)) && (col_eff >= COL_BITS'(2));
        col_new[0] = line0_rd;
        col_new[1] = line1_rd;
        col_new[2] = in_data;
    end

    // Raster position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_valid) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_eff + ROW_BITS'(1);
            end else begin
                col_q <= col_eff + COL_BITS'(1);
                row_q <= row_eff;
            end
        end else if (frame_start) begin
            col_q <= '0;
            row_q <= '0;
        end
    end

    conv33_line_buf #(
        .DEPTH     (IMG_W),
        .WIDTH     (DATA_WIDTH),
        .ADDR_BITS (COL_BITS)
    ) u_line0 (
        .clk       (clk),
        .we        (in_valid),
        .addr      (col_eff),
        .wr_data   (line1_rd),
        .rd_data_c (line0_rd)
    );

    conv33_line_buf #(
        .DEPTH     (IMG_W),
        .WIDTH     (DATA_WIDTH),
        .ADDR_BITS (COL_BITS)
    ) u_line1 (
        .clk       (clk),
        .we        (in_valid),
        .addr      (col_eff),
        .wr_data   (in_data),
        .rd_data_c (line1_rd)
    );

    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int i = 0; i < int'(WIN_K); i++) begin
                win_sr[i][0] <= win_sr[i][1];
                win_sr[i][1] <= col_new[i];
            end
        end
    end

    // Registered window outputs; values hold between valid windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(WIN_K); i++) begin
                for (int j = 0; j < int'(WIN_K); j++) begin
                    win_q[i][j] <= '0;
                end
            end
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= win_hit;
            frame_done <= win_hit && row_last && col_last;
            if (win_hit) begin
                for (int i = 0; i < int'(WIN_K); i++) begin
                    win_q[i][0] <= win_sr[i][0];
                    win_q[i][1] <= win_sr[i][1];
                    win_q[i][2] <= col_new[i];
                end
                win_row <= row_eff - ROW_BITS'(2);
                win_col <= col_eff - COL_BITS'(2);
            end
        end
    end

    assign data_0_0 = win_q[0][0];
    assign data_0_1 = win_q[0][1];
    assign data_0_2 = win_q[0][2];
    assign data_1_0 = win_q[1][0];
    assign data_1_1 = win_q[1][1];
    assign data_1_2 = win_q[1][2];
    assign data_2_0 = win_q[2][0];
    assign data_2_1 = win_q[2][1];
    assign data_2_2 = win_q[2][2];

endmodule

// File: tb/tb_conv33_window_gen.sv
// Directed bench for conv33_window_gen on a 5x5 image: contiguous, gapped,
// back-to-back, restarted, reset-interrupted and signed-extreme streams.
module tb_conv33_window_gen;

    localparam int unsigned W  = 5;
    localparam int unsigned H  = 5;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [DW-1:0] data_0_0, data_0_1, data_0_2;
    logic [DW-1:0] data_1_0, data_1_1, data_1_2;
    logic [DW-1:0] data_2_0, data_2_1, data_2_2;
    logic          win_valid;
    logic [2:0]    win_row;
    logic [2:0]    win_col;
    logic          frame_done;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            pr;
    int            pc;
    int            win_count;
    logic [DW-1:0] frame_pix [W*H];
    logic [DW-1:0] last_win  [9];
    logic [DW-1:0] win_out   [9];

    conv33_window_gen #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H),
        .COL_BITS   (3),
        .ROW_BITS   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .data_0_0    (data_0_0),
        .data_0_1    (data_0_1),
        .data_0_2    (data_0_2),
        .data_1_0    (data_1_0),
        .data_1_1    (data_1_1),
        .data_1_2    (data_1_2),
        .data_2_0    (data_2_0),
        .data_2_1    (data_2_1),
        .data_2_2    (data_2_2),
        .win_valid   (win_valid),
        .win_row     (win_row),
        .win_col     (win_col),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        win_out[0] = data_0_0;
        win_out[1] = data_0_1;
        win_out[2] = data_0_2;
        win_out[3] = data_1_0;
        win_out[4] = data_1_1;
        win_out[5] = data_1_2;
        win_out[6] = data_2_0;
        win_out[7] = data_2_1;
        win_out[8] = data_2_2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hand-written window, packed row-major with data_0_0 in the top byte.
    task automatic check_win(input string tag, input logic [71:0] exp);
        for (int k = 0; k < 9; k++) begin
            check(tag, 32'(win_out[k]), 32'(exp[71-8*k -: 8]));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check("gap_valid", 32'(win_valid), 32'd0);
            check("gap_done", 32'(frame_done), 32'd0);
            for (int i = 0; i < 9; i++) begin
                check("gap_hold", 32'(win_out[i]), 32'(last_win[i]));
            end
        end
    endtask

    task automatic send(input logic [DW-1:0] pix, input bit fs);
        if (fs) begin
            pr = 0;
            pc = 0;
        end
        in_valid    = 1'b1;
        in_data     = pix;
        frame_start = fs;
        frame_pix[pr*W+pc] = pix;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        if (pr >= 2 && pc >= 2) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    last_win[i*3+j] = frame_pix[(pr-2+i)*W + (pc-2+j)];
                end
            end
            check("win_valid", 32'(win_valid), 32'd1);
            check("win_row", 32'(win_row), 32'(pr-2));
            check("win_col", 32'(win_col), 32'(pc-2));
            for (int k = 0; k < 9; k++) begin
                check("win_data", 32'(win_out[k]), 32'(last_win[k]));
            end
            check("frame_done", 32'(frame_done), 32'((pr == H-1) && (pc == W-1)));
            win_count++;
        end else begin
            check("no_valid", 32'(win_valid), 32'd0);
            check("no_done", 32'(frame_done), 32'd0);
        end
        if (pc == W-1) begin
            pc = 0;
            pr = (pr == H-1) ? 0 : pr + 1;
        end else begin
            pc++;
        end
    endtask

    task automatic stream(input int first, input int last, input bit fs_first,
                          input bit gaps, input bit alt);
        logic [DW-1:0] pix;
        for (int i = first; i <= last; i++) begin
            if (gaps) idle(int'($urandom_range(4, 1)));
            if (alt) pix = (i % 2 == 0) ? 8'h7F : 8'h80;
            else     pix = 8'(i);
            send(pix, fs_first && (i == first));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'(win_valid), 32'd0);
        check(tag, 32'(frame_done), 32'd0);
        check(tag, 32'(win_row), 32'd0);
        check(tag, 32'(win_col), 32'd0);
        for (int k = 0; k < 9; k++) begin
            check(tag, 32'(win_out[k]), 32'd0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        pr          = 0;
        pc          = 0;
        win_count   = 0;
        for (int k = 0; k < 9; k++) last_win[k] = '0;

        #13;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Contiguous 0..24
        stream(0, 12, 1'b0, 1'b0, 1'b0);
        check_win("s1_first", {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
        stream(13, 24, 1'b0, 1'b0, 1'b0);
        check_win("s1_last", {8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19, 8'd22, 8'd23, 8'd24});
        check("s1_count", 32'(win_count), 32'd9);
        idle(2);

        // Same stream with idle gaps
        win_count = 0;
        stream(0, 24, 1'b0, 1'b1, 1'b0);
        check_win("s2_last", {8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19, 8'd22, 8'd23, 8'd24});
        check("s2_count", 32'(win_count), 32'd9);

        // Back-to-back frame 100..124
        win_count = 0;
        stream(100, 112, 1'b0, 1'b0, 1'b0);
        check_win("s3_first", {8'd100, 8'd101, 8'd102, 8'd105, 8'd106, 8'd107, 8'd110, 8'd111, 8'd112});
        stream(113, 124, 1'b0, 1'b0, 1'b0);
        check("s3_count", 32'(win_count), 32'd9);
        idle(1);

        // Abort after 17 pixels with frame_start + pixel 200
        win_count = 0;
        stream(0, 16, 1'b0, 1'b0, 1'b0);
        check("s4_partial", 32'(win_count), 32'd3);
        stream(200, 212, 1'b1, 1'b0, 1'b0);
        check_win("s4_first", {8'd200, 8'd201, 8'd202, 8'd205, 8'd206, 8'd207, 8'd210, 8'd211, 8'd212});
        stream(213, 224, 1'b0, 1'b0, 1'b0);
        check("s4_count", 32'(win_count), 32'd12);
        idle(1);

        // Reset mid-frame after pixel 13
        stream(0, 13, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("s5_async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        pr  = 0;
        pc  = 0;
        for (int k = 0; k < 9; k++) last_win[k] = '0;
        idle(1);
        win_count = 0;
        stream(0, 12, 1'b0, 1'b0, 1'b0);
        check_win("s5_first", {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
        stream(13, 24, 1'b0, 1'b0, 1'b0);
        check_win("s5_last", {8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19, 8'd22, 8'd23, 8'd24});
        check("s5_count", 32'(win_count), 32'd9);

        // Alternating +127 / -128
        stream(0, 12, 1'b0, 1'b0, 1'b1);
        check_win("s6_first", {8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F});
        check("s6_d22", 32'(data_2_2), 32'h7F);
        check("s6_d21", 32'(data_2_1), 32'h80);
        stream(13, 24, 1'b0, 1'b0, 1'b1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
